// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit with saturation, serial change, reject pulses.
// Optional refund on cancel is enabled by defining VENDING_CANCEL_EN.
module vending_fsm_param #(
  parameter int unsigned DIV_W      = 25,
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned COIN1      = 1,
  parameter int unsigned COIN2      = 2,
  parameter int unsigned COIN3      = 5,
  parameter logic [(2**SEL_W)*CREDIT_W-1:0] PRICES = {6'd8, 6'd6, 6'd4, 6'd3},
  parameter int unsigned VEND_TICKS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          moneda,
  input  logic [SEL_W-1:0]    seleccion,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic [SEL_W-1:0]    producto,
  output logic                listo,
  output logic                cambio,
  output logic [CREDIT_W-1:0] credito,
  output logic                coin_rej,
  output logic                busy
);

  localparam int unsigned CNT_W = (VEND_TICKS > 1) ? $clog2(VEND_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          prev_q;
  logic [SEL_W-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0]    vcnt_q, vcnt_d;

  logic                tick;
  logic                coin_evt;
  logic                cancel_req;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;

  assign tick = &div_q;

`ifdef VENDING_CANCEL_EN
  assign cancel_req = cancel && (state_q == S_CREDIT);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_req    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      state_q  <= S_IDLE;
      credit_q <= '0;
      prev_q   <= '0;
      prod_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
      if (tick) begin
        prev_q <= moneda;
      end
      state_q  <= state_d;
      credit_q <= credit_d;
      prod_q   <= prod_d;
      vcnt_q   <= vcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    vcnt_d   = vcnt_q;
    cambio   = 1'b0;
    coin_rej = 1'b0;
    coin_evt = (moneda != 2'b00) && (prev_q == 2'b00);
    case (moneda)
      2'b01:   coin_val = CREDIT_W'(COIN1);
      2'b10:   coin_val = CREDIT_W'(COIN2);
      2'b11:   coin_val = CREDIT_W'(COIN3);
      default: coin_val = '0;
    endcase
    // One extra bit catches overflow: the coin fits only if the carry stays clear.
    sum   = {1'b0, credit_q} + {1'b0, coin_val};
    price = PRICES[int'(seleccion)*CREDIT_W +: CREDIT_W];

    if (tick) begin
      case (state_q)
        S_IDLE, S_CREDIT: begin
          if (coin_evt) begin
            if (!sum[CREDIT_W]) begin
              credit_d = sum[CREDIT_W-1:0];
              state_d  = S_CREDIT;
            end else begin
              coin_rej = 1'b1;
            end
          end else if (cancel_req) begin
            state_d = S_CHANGE;
          end else if (sel_valid && (credit_q >= price)) begin
            prod_d   = seleccion;
            credit_d = credit_q - price;
            vcnt_d   = '0;
            state_d  = S_VEND;
          end
        end
        S_VEND: begin
          coin_rej = coin_evt;
          if (vcnt_q == CNT_W'(VEND_TICKS - 1)) begin
            state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
          end else begin
            vcnt_d = vcnt_q + CNT_W'(1);
          end
        end
        S_CHANGE: begin
          coin_rej = coin_evt;
          cambio   = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign producto = prod_q;
  assign listo    = (state_q == S_VEND);
  assign busy     = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign credito  = credit_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: vector table, corner sequences and random traffic vs a credit-level model.
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] moneda;
  logic [1:0] seleccion;
  logic       sel_valid;
  logic       cancel;
  logic [1:0] producto;
  logic       listo, cambio, coin_rej, busy;
  logic [5:0] credito;

  logic [1:0] moneda2;
  logic [1:0] producto2;
  logic       listo2, cambio2, coin_rej2, busy2;
  logic [2:0] credito2;

  always #5 clk = ~clk;

  vending_fsm_param #(.DIV_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .moneda(moneda), .seleccion(seleccion),
    .sel_valid(sel_valid), .cancel(cancel), .producto(producto), .listo(listo),
    .cambio(cambio), .credito(credito), .coin_rej(coin_rej), .busy(busy)
  );

  vending_fsm_param #(.DIV_W(2), .CREDIT_W(3), .PRICES({3'd7, 3'd6, 3'd4, 3'd3})) dut_sat (
    .clk(clk), .rst_n(rst_n), .moneda(moneda2), .seleccion(2'b00),
    .sel_valid(1'b0), .cancel(1'b0), .producto(producto2), .listo(listo2),
    .cambio(cambio2), .credito(credito2), .coin_rej(coin_rej2), .busy(busy2)
  );

`ifdef VENDING_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif
  localparam int CMAX       = 63;
  localparam int VEND_TICKS = 2;

  int n_chk  = 0;
  int n_fail = 0;
  int coin_v[4] = '{0, 1, 2, 5};
  int price[4]  = '{3, 4, 6, 8};

  // Model: credit, ticks of listo still owed, and whether change is being paid out.
  int         m_credit, m_left, m_prod;
  bit         m_refund;
  logic [1:0] m_prev;

  bit last_camb, last_rej, last_rej2;

  typedef struct {
    logic [1:0] mon;
    int         sel;
    bit         sv;
    int         credit;
    bit         lst;
    bit         bsy;
    int         prod;
    bit         camb;
    bit         rej;
  } vec_t;

  vec_t tv[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_left = 0; m_prod = 0; m_refund = 0; m_prev = 2'b00;
  endtask

  task automatic model_tick(input logic [1:0] mon, input int sel, input bit sv, input bit can,
                            output bit e_camb, output bit e_rej);
    bit coin;
    coin   = (mon != 2'b00) && (m_prev == 2'b00);
    e_camb = 1'b0;
    e_rej  = 1'b0;
    if (m_left > 0) begin
      e_rej = coin;
      m_left--;
      if (m_left == 0 && m_credit > 0) m_refund = 1'b1;
    end else if (m_refund) begin
      e_rej  = coin;
      e_camb = 1'b1;
      m_credit--;
      if (m_credit == 0) m_refund = 1'b0;
    end else if (coin) begin
      if (m_credit + coin_v[mon] <= CMAX) m_credit += coin_v[mon];
      else e_rej = 1'b1;
    end else if (CANCEL_ON && can && m_credit > 0) begin
      m_refund = 1'b1;
    end else if (sv && m_credit >= price[sel]) begin
      m_prod   = sel;
      m_credit -= price[sel];
      m_left   = VEND_TICKS;
    end
    m_prev = mon;
  endtask

  // Enters aligned just after a tick edge; leaves aligned just after the next one.
  task automatic step(input logic [1:0] mon, input int sel, input bit sv, input bit can);
    bit e_camb, e_rej;
    moneda    = mon;
    seleccion = sel[1:0];
    sel_valid = sv;
    cancel    = can;
    model_tick(mon, sel, sv, can, e_camb, e_rej);
    @(posedge clk); #1;
    chk("cambio_offtick", cambio, 0);
    chk("coin_rej_offtick", coin_rej, 0);
    repeat (2) @(posedge clk);
    #1;
    last_camb = cambio;
    last_rej  = coin_rej;
    last_rej2 = coin_rej2;
    @(posedge clk); #1;
    chk("cambio", last_camb, e_camb);
    chk("coin_rej", last_rej, e_rej);
    chk("credito", credito, m_credit);
    chk("listo", listo, m_left > 0);
    chk("busy", busy, (m_left > 0) || m_refund);
    chk("producto", producto, m_prod);
  endtask

  initial begin
    int pulses, listo_seen;
    logic [1:0] rm;

    tv[0]  = '{2'b01, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[1]  = '{2'b01, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[2]  = '{2'b01, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[3]  = '{2'b00, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[4]  = '{2'b11, 0, 0, 6, 0, 0, 0, 0, 0};
    tv[5]  = '{2'b11, 0, 0, 6, 0, 0, 0, 0, 0};
    tv[6]  = '{2'b11, 0, 0, 6, 0, 0, 0, 0, 0};
    tv[7]  = '{2'b00, 2, 1, 0, 1, 1, 2, 0, 0};
    tv[8]  = '{2'b00, 0, 0, 0, 1, 1, 2, 0, 0};
    tv[9]  = '{2'b00, 0, 0, 0, 0, 0, 2, 0, 0};
    tv[10] = '{2'b00, 0, 0, 0, 0, 0, 2, 0, 0};
    tv[11] = '{2'b11, 0, 0, 5, 0, 0, 2, 0, 0};
    tv[12] = '{2'b00, 0, 1, 2, 1, 1, 0, 0, 0};
    tv[13] = '{2'b00, 0, 0, 2, 1, 1, 0, 0, 0};
    tv[14] = '{2'b00, 0, 0, 2, 0, 1, 0, 0, 0};
    tv[15] = '{2'b00, 0, 0, 1, 0, 1, 0, 1, 0};
    tv[16] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[17] = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[18] = '{2'b10, 0, 0, 2, 0, 0, 0, 0, 0};
    tv[19] = '{2'b00, 0, 0, 2, 0, 0, 0, 0, 0};
    tv[20] = '{2'b10, 0, 0, 4, 0, 0, 0, 0, 0};
    tv[21] = '{2'b00, 3, 1, 4, 0, 0, 0, 0, 0};
    tv[22] = '{2'b01, 0, 1, 5, 0, 0, 0, 0, 0};
    tv[23] = '{2'b00, 0, 1, 2, 1, 1, 0, 0, 0};
    tv[24] = '{2'b10, 0, 0, 2, 1, 1, 0, 0, 1};
    tv[25] = '{2'b00, 0, 0, 2, 0, 1, 0, 0, 0};
    tv[26] = '{2'b00, 0, 0, 1, 0, 1, 0, 1, 0};
    tv[27] = '{2'b00, 0, 0, 0, 0, 0, 0, 1, 0};

    rst_n = 1'b0; moneda = 2'b00; seleccion = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
    moneda2 = 2'b00;
    model_reset();
    #1;
    chk("rst_credito", credito, 0);
    chk("rst_listo", listo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_producto", producto, 0);
    chk("rst_cambio", cambio, 0);
    chk("rst_coin_rej", coin_rej, 0);
    #22 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      step(tv[i].mon, tv[i].sel, tv[i].sv, 1'b0);
      chk($sformatf("tv%0d_credito", i), credito, tv[i].credit);
      chk($sformatf("tv%0d_listo", i), listo, tv[i].lst);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d_producto", i), producto, tv[i].prod);
      chk($sformatf("tv%0d_cambio", i), last_camb, tv[i].camb);
      chk($sformatf("tv%0d_coin_rej", i), last_rej, tv[i].rej);
    end

    step(2'b01, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    chk("cancel_setup_credito", credito, 3);
`ifdef VENDING_CANCEL_EN
    pulses = 0; listo_seen = 0;
    step(2'b00, 0, 0, 1);
    pulses += last_camb; listo_seen += listo;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 0, 0, 0);
      pulses += last_camb; listo_seen += listo;
    end
    chk("cancel_pulses", pulses, 3);
    chk("cancel_listo_seen", listo_seen, 0);
    chk("cancel_final_credito", credito, 0);
`else
    step(2'b00, 0, 0, 1);
    chk("cancel_ignored_credito", credito, 3);
    chk("cancel_ignored_busy", busy, 0);
    step(2'b00, 0, 1, 0);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    chk("cancel_cleanup_credito", credito, 0);
`endif

    moneda2 = 2'b11; step(2'b00, 0, 0, 0);
    chk("sat_credito_5", credito2, 5); chk("sat_rej_a", last_rej2, 0);
    moneda2 = 2'b00; step(2'b00, 0, 0, 0);
    moneda2 = 2'b10; step(2'b00, 0, 0, 0);
    chk("sat_credito_7", credito2, 7); chk("sat_rej_b", last_rej2, 0);
    moneda2 = 2'b00; step(2'b00, 0, 0, 0);
    moneda2 = 2'b01; step(2'b00, 0, 0, 0);
    chk("sat_rej_c", last_rej2, 1); chk("sat_credito_hold", credito2, 7);
    moneda2 = 2'b00; step(2'b00, 0, 0, 0);
    chk("sat_rej_once", last_rej2, 0);

    step(2'b11, 0, 0, 0);
    step(2'b00, 1, 1, 0);
    step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_producto", producto, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_credito", credito, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_listo", listo, 0);
    chk("mid_rst_producto", producto, 0);
    chk("mid_rst_cambio", cambio, 0);
    chk("mid_rst_coin_rej", coin_rej, 0);
    chk("mid_rst_sat_credito", credito2, 0);
    #20 rst_n = 1'b1;
    model_reset();
    step(2'b00, 0, 0, 0);
    chk("post_rst_cambio", last_camb, 0);

    for (int i = 0; i < 300; i++) begin
      rm = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(rm, $urandom_range(0, 3), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
